// File: rtl/imm_gen.sv
// RV32I immediate generator.
// Decodes the opcode, extracts the sign-extended immediate and registers it.
module imm_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic [2:0]  fmt,
    output logic        valid_out
);

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    logic [6:0]  opcode;
    logic        sign;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_next;
    logic [2:0]  fmt_next;

    assign opcode = instr[6:0];
    assign sign   = instr[31];

    assign imm_i = {{20{sign}}, instr[31:20]};
    assign imm_s = {{20{sign}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{sign}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{sign}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    // Select format and immediate from the opcode alone.
    always_comb begin
        imm_next = 32'd0;
        fmt_next = FMT_NONE;
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM: begin
                imm_next = imm_i;
                fmt_next = FMT_I;
            end
            STORE: begin
                imm_next = imm_s;
                fmt_next = FMT_S;
            end
            BRANCH: begin
                imm_next = imm_b;
                fmt_next = FMT_B;
            end
            LUI, AUIPC: begin
                imm_next = imm_u;
                fmt_next = FMT_U;
            end
            JAL: begin
                imm_next = imm_j;
                fmt_next = FMT_J;
            end
            default: begin
                imm_next = 32'd0;
                fmt_next = FMT_NONE;
            end
        endcase
    end

    // Register the decode; hold imm/fmt while no valid instruction arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm       <= 32'd0;
            fmt       <= FMT_NONE;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                imm <= imm_next;
                fmt <= fmt_next;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Directed testbench for imm_gen.
// Hand-computed vectors, one checking task, summary at end.
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        valid_out;

    int checks;
    int errors;

    imm_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .instr     (instr),
        .imm       (imm),
        .fmt       (fmt),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply inputs at the falling edge, sample 1 time unit after rising.
    task automatic step(input logic [31:0] i, input logic v);
        @(negedge clk);
        instr    = i;
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag,
                              input logic [31:0] e_imm,
                              input logic [2:0]  e_fmt,
                              input logic        e_vld);
        check({tag, ".imm"}, imm, e_imm);
        check({tag, ".fmt"}, {29'd0, fmt}, {29'd0, e_fmt});
        check({tag, ".vld"}, {31'd0, valid_out}, {31'd0, e_vld});
    endtask

    typedef struct {
        string       tag;
        logic [31:0] ins;
        logic [31:0] e_imm;
        logic [2:0]  e_fmt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        instr    = 32'd0;

        vecs.push_back('{"addi",  32'h11100013, 32'h00000111, 3'd1});
        vecs.push_back('{"sb",    32'h10000823, 32'h00000110, 3'd2});
        vecs.push_back('{"beq",   32'hFE000CE3, 32'hFFFFFFF8, 3'd3});
        vecs.push_back('{"lui",   32'hFFFFA037, 32'hFFFFA000, 3'd4});
        vecs.push_back('{"jal",   32'h0020006F, 32'h00000002, 3'd5});
        vecs.push_back('{"lw",    32'hFFC02083, 32'hFFFFFFFC, 3'd1});
        vecs.push_back('{"jalr",  32'h80000067, 32'hFFFFF800, 3'd1});
        vecs.push_back('{"srai",  32'h4030D093, 32'h00000403, 3'd1});
        vecs.push_back('{"ecall", 32'h00000073, 32'h00000000, 3'd1});
        vecs.push_back('{"sw",    32'hFE002FA3, 32'hFFFFFFFF, 3'd2});
        vecs.push_back('{"auipc", 32'h12345017, 32'h12345000, 3'd4});
        vecs.push_back('{"jalneg",32'hFFFFF06F, 32'hFFFFFFFE, 3'd5});
        vecs.push_back('{"unk",   32'hFFFFFFFF, 32'h00000000, 3'd0});

        #12;
        expect_out("reset", 32'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            step(vecs[k].ins, 1'b1);
            expect_out(vecs[k].tag, vecs[k].e_imm, vecs[k].e_fmt, 1'b1);
        end

        // Load a nonzero value, then an R-type op clears it.
        step(32'h11100013, 1'b1);
        expect_out("addi2", 32'h00000111, 3'd1, 1'b1);
        step(32'h00000033, 1'b1);
        expect_out("rtype", 32'd0, 3'd0, 1'b1);

        // Hold: with valid_in low, imm/fmt keep the last valid result.
        step(32'hFFFFA037, 1'b1);
        expect_out("lui2", 32'hFFFFA000, 3'd4, 1'b1);
        step(32'h0020006F, 1'b0);
        expect_out("hold1", 32'hFFFFA000, 3'd4, 1'b0);
        step(32'h10000823, 1'b0);
        expect_out("hold2", 32'hFFFFA000, 3'd4, 1'b0);

        // Mid-stream reset between edges clears outputs at once.
        @(negedge clk);
        instr    = 32'hFE000CE3;
        valid_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 32'd0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("rst_held", 32'd0, 3'd0, 1'b0);

        // First output after release comes from first post-reset sample.
        @(negedge clk);
        rst_n = 1'b1;
        instr = 32'h0020006F;
        @(posedge clk);
        #1;
        expect_out("post_rst", 32'h00000002, 3'd5, 1'b1);

        step(32'h00000000, 1'b0);
        expect_out("idle", 32'h00000002, 3'd5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
